// File: rtl/mixed_signal_classifier_seq.sv
// mixed_signal_classifier_seq: bias, per-channel settle, oversampled majority vote and class encode.
// Define MSC_CMP_SYNC_EN to pass cmp_in through a 2-flop synchronizer before voting.
module mixed_signal_classifier_seq #(
  parameter int N_CH       = 4,
  parameter int BIAS_CYC   = 16,
  parameter int SETTLE_CYC = 8,
  parameter int N_SAMP     = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    abort,
  input  logic                    cmp_in,
  output logic                    bias_en,
  output logic [$clog2(N_CH)-1:0] ch_sel,
  output logic                    sample_strobe,
  output logic                    busy,
  output logic                    done,
  output logic [N_CH-1:0]         result,
  output logic [$clog2(N_CH)-1:0] class_id,
  output logic                    class_valid
);
  localparam int CW   = $clog2(N_CH);
  localparam int VW   = $clog2(N_SAMP + 1);
  localparam int TMAX = BIAS_CYC > SETTLE_CYC ? (BIAS_CYC > N_SAMP ? BIAS_CYC : N_SAMP)
                                              : (SETTLE_CYC > N_SAMP ? SETTLE_CYC : N_SAMP);
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, BIAS, SETTLE, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d, last_tmr;
  logic [VW-1:0] vote_q, vote_d, vote_sum;
  logic [CW-1:0] ch_q, ch_d, class_id_q, class_id_d;
  logic [N_CH-1:0] shadow_q, shadow_d, result_q, result_d;
  logic busy_q, busy_d, strobe_q, strobe_d, done_q, done_d, class_valid_q, class_valid_d;
  logic cmp_c, tmr_end, last_ch, ch_bit;
`ifdef MSC_CMP_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) sync_q <= rst ? 2'b00 : {sync_q[0], cmp_in};
  assign cmp_c = sync_q[1];
`else
  assign cmp_c = cmp_in;
`endif
  assign last_tmr = state_q == BIAS   ? TW'(BIAS_CYC - 1) :
                    state_q == SETTLE ? TW'(SETTLE_CYC - 1) : TW'(N_SAMP - 1);
  assign tmr_end  = tmr_q == last_tmr;
  assign last_ch  = ch_q == CW'(N_CH - 1);
  assign vote_sum = vote_q + VW'(cmp_c);
  assign ch_bit   = vote_sum > VW'(N_SAMP / 2);
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? BIAS : IDLE;
      BIAS:    state_d = tmr_end ? SETTLE : BIAS;
      SETTLE:  state_d = tmr_end ? SAMPLE : SETTLE;
      SAMPLE:  state_d = !tmr_end ? SAMPLE : last_ch ? DONE : SETTLE;
      DONE:    state_d = cont ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  always_comb begin
    tmr_d    = (state_d == state_q && state_q != IDLE) ? tmr_q + 1'b1 : '0;
    vote_d   = (state_q == SAMPLE && state_d == SAMPLE) ? vote_sum : '0;
    ch_d     = (state_q == SAMPLE && state_d == SETTLE) ? ch_q + 1'b1 :
               (state_q == DONE || state_d == IDLE || state_d == BIAS) ? '0 : ch_q;
    shadow_d = shadow_q;
    if (state_q == SAMPLE && tmr_end && state_d != IDLE) shadow_d[ch_q] = ch_bit;
    result_d = state_d == DONE ? shadow_d : result_q;
    class_id_d = class_id_q;
    if (state_d == DONE) begin
      class_id_d = '0;
      for (int i = N_CH - 1; i >= 0; i--) if (shadow_d[i]) class_id_d = CW'(i);
    end
    class_valid_d = state_d == DONE ? |shadow_d : class_valid_q;
  end
  always_comb begin
    busy_d   = state_d != IDLE;
    strobe_d = state_d == SAMPLE;
    done_d   = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q         <= '0;
      vote_q        <= '0;
      ch_q          <= '0;
      shadow_q      <= '0;
      result_q      <= '0;
      class_id_q    <= '0;
      class_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      strobe_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      vote_q        <= vote_d;
      ch_q          <= ch_d;
      shadow_q      <= shadow_d;
      result_q      <= result_d;
      class_id_q    <= class_id_d;
      class_valid_q <= class_valid_d;
      busy_q        <= busy_d;
      strobe_q      <= strobe_d;
      done_q        <= done_d;
    end
  end
  assign bias_en       = busy_q;
  assign busy          = busy_q;
  assign ch_sel        = ch_q;
  assign sample_strobe = strobe_q;
  assign done          = done_q;
  assign result        = result_q;
  assign class_id      = class_id_q;
  assign class_valid   = class_valid_q;
endmodule

// File: tb/tb_mixed_signal_classifier_seq.sv
// tb_mixed_signal_classifier_seq: directed checks of timing, voting, continuous mode, abort and reset.
module tb_mixed_signal_classifier_seq;
`ifdef MSC_CMP_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif
  logic clk, rst, start, cont, abort, cmp_in;
  logic bias_en, sample_strobe, busy, done, class_valid;
  logic [1:0] ch_sel, class_id;
  logic [3:0] result;
  int errors = 0;
  int checks = 0;
  int n = 0;
  int mode = 0;
  mixed_signal_classifier_seq dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort), .cmp_in(cmp_in),
    .bias_en(bias_en), .ch_sel(ch_sel), .sample_strobe(sample_strobe), .busy(busy),
    .done(done), .result(result), .class_id(class_id), .class_valid(class_valid)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // Comparator level wanted for sample cycle m (cycles after the start edge).
  function automatic logic want(input int md, input int m);
    int k, o, j;
    if (m < 16) return 1'b0;
    k = (m - 16) / 15;
    o = (m - 16) % 15;
    j = o - 8;
    case (md)
      1:       return k == 2;
      2:       return o >= 8 && ((k == 0 && j < 4) || (k == 1 && j < 3));
      3:       return m % 2 == 1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    n++;
    cmp_in = want(mode, n + DLY);
  endtask
  task automatic go(input int md);
    mode = md;
    n = -1;
    cmp_in = want(mode, n + DLY);
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic run_to(input int upto, input int d1, input int d2);
    while (n < upto) begin
      tick();
      chk("done_timing", done, n == d1 || n == d2);
    end
  endtask
  initial begin
    rst = 1; start = 0; cont = 0; abort = 0; cmp_in = 0;
    tick(); tick();
    chk("rst_bias_en", bias_en, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_class_id", class_id, 0);
    chk("rst_class_valid", class_valid, 0);
    rst = 0;
    tick();
    // continuous mode, comparator low
    cont = 1;
    go(0);
    while (n < 137) begin
      chk("cont_bias_en", bias_en, 1);
      if (n == 77) cont = 0;
      tick();
      chk("cont_done", done, n == 76 || n == 137);
    end
    chk("cont_result", result, 0);
    chk("cont_class_valid", class_valid, 0);
    run_to(138, -1, -1);
    chk("cont_busy_end", busy, 0);
    // only channel 2 high
    go(1);
    chk("t1_busy_E", busy, 1);
    chk("t1_bias_E", bias_en, 1);
    run_to(16, 76, -1);
    chk("t1_ch_sel16", ch_sel, 0);
    run_to(23, 76, -1);
    chk("t1_strobe23", sample_strobe, 0);
    run_to(24, 76, -1);
    chk("t1_strobe24", sample_strobe, 1);
    run_to(39, 76, -1);
    chk("t1_ch_sel39", ch_sel, 1);
    run_to(76, 76, -1);
    chk("t1_result", result, 4'b0100);
    chk("t1_class_id", class_id, 2);
    chk("t1_class_valid", class_valid, 1);
    chk("t1_busy76", busy, 1);
    run_to(77, 76, -1);
    chk("t1_busy77", busy, 0);
    chk("t1_bias77", bias_en, 0);
    // 4/7 on ch0, 3/7 on ch1
    go(2);
    run_to(76, 76, -1);
    chk("t2_result", result, 4'b0001);
    chk("t2_class_id", class_id, 0);
    chk("t2_class_valid", class_valid, 1);
    run_to(77, 76, -1);
    // abort mid-conversion
    go(1);
    run_to(30, -1, -1);
    abort = 1;
    run_to(31, -1, -1);
    abort = 0;
    chk("ab_busy", busy, 0);
    chk("ab_bias_en", bias_en, 0);
    chk("ab_ch_sel", ch_sel, 0);
    chk("ab_result_held", result, 4'b0001);
    run_to(90, -1, -1);
    chk("ab_idle", busy, 0);
    // start re-asserted during SAMPLE is ignored
    go(1);
    run_to(25, 76, -1);
    start = 1;
    run_to(26, 76, -1);
    start = 0;
    run_to(76, 76, -1);
    chk("rs_result", result, 4'b0100);
    chk("rs_class_id", class_id, 2);
    run_to(77, 76, -1);
    chk("rs_busy77", busy, 0);
    // start and abort together in IDLE
    start = 1; abort = 1;
    tick(); tick();
    chk("sa_busy", busy, 0);
    chk("sa_bias_en", bias_en, 0);
    start = 0; abort = 0;
    // reset mid-conversion
    go(1);
    run_to(50, -1, -1);
    rst = 1;
    tick();
    rst = 0;
    chk("mr_busy", busy, 0);
    chk("mr_bias_en", bias_en, 0);
    chk("mr_strobe", sample_strobe, 0);
    chk("mr_ch_sel", ch_sel, 0);
    chk("mr_done", done, 0);
    chk("mr_result", result, 0);
    chk("mr_class_valid", class_valid, 0);
    tick();
    // comparator toggling every cycle
    go(3);
    run_to(76, 76, -1);
    chk("tg_result", result, 4'b1010);
    chk("tg_class_id", class_id, 1);
    chk("tg_class_valid", class_valid, 1);
    run_to(77, 76, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
